// File: rtl/reg_wb_sched_pkg.sv
// Shared constants and types for the register write-back scheduler.
package reg_wb_sched_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_REG_NUM = 32;
    localparam int REG_IDX_W   = $clog2(DEF_REG_NUM);

    localparam logic [DEF_XLEN-1:0] ZERO_WORD  = '0;
    localparam logic                RST_ENABLE = 1'b0;

    typedef enum logic {
        RR_EX,
        RR_LSU
    } rr_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_EX,
        GNT_LSU
    } gnt_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
    } wb_ctl_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write bitmap: decode claims set, write-back retires clear.
module reg_scoreboard
    import reg_wb_sched_pkg::*;
#(
    parameter int REG_NUM = DEF_REG_NUM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_valid_i,
    input  logic [REG_IDX_W-1:0] set_rd_i,
    input  logic                 clr_valid_i,
    input  logic [REG_IDX_W-1:0] clr_rd_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o,
    output logic [REG_NUM-1:0]   pending_o
);

    logic [REG_NUM-1:0] pending_q;
    logic [REG_NUM-1:0] pending_d;

    // Set is applied last so a newer producer survives the retire.
    always_comb begin
        pending_d = pending_q;
        if (clr_valid_i) begin
            pending_d[clr_rd_i] = 1'b0;
        end
        if (set_valid_i && (set_rd_i != '0)) begin
            pending_d[set_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rs1_busy_o = pending_q[rs1_i] &
                        ~(clr_valid_i & (clr_rd_i == rs1_i));
    assign rs2_busy_o = pending_q[rs2_i] &
                        ~(clr_valid_i & (clr_rd_i == rs2_i));
    assign pending_o  = pending_q;

endmodule

// File: rtl/reg_wb_sched.sv
// Round-robin arbiter of ex/lsu write-backs onto one register-file port.
module reg_wb_sched
    import reg_wb_sched_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int REG_NUM = DEF_REG_NUM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_wb_valid_i,
    input  logic [REG_IDX_W-1:0] ex_wb_rd_i,
    input  logic [XLEN-1:0]      ex_wb_data_i,
    output logic                 ex_wb_ready_o,
    input  logic                 lsu_wb_valid_i,
    input  logic [REG_IDX_W-1:0] lsu_wb_rd_i,
    input  logic [XLEN-1:0]      lsu_wb_data_i,
    output logic                 lsu_wb_ready_o,
    output logic                 rd_req_wr_valid_o,
    output logic [REG_IDX_W-1:0] rd_o,
    output logic [XLEN-1:0]      rd_data_o,
    input  logic                 claim_valid_i,
    input  logic [REG_IDX_W-1:0] claim_rd_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o,
    output logic [REG_NUM-1:0]   pending_o
);

    rr_e             rr_q;
    rr_e             rr_d;
    gnt_e            gnt;
    wb_ctl_t         wb_q;
    wb_ctl_t         wb_d;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;

    // Pointer moves to the loser only when both contend.
    always_comb begin
        gnt  = GNT_NONE;
        rr_d = rr_q;
        unique case (1'b1)
            ex_wb_valid_i && lsu_wb_valid_i: begin
                gnt  = (rr_q == RR_EX) ? GNT_EX : GNT_LSU;
                rr_d = (rr_q == RR_EX) ? RR_LSU : RR_EX;
            end
            ex_wb_valid_i && !lsu_wb_valid_i: begin
                gnt = GNT_EX;
            end
            !ex_wb_valid_i && lsu_wb_valid_i: begin
                gnt = GNT_LSU;
            end
            default: begin
            end
        endcase
    end

    assign ex_wb_ready_o  = (gnt == GNT_EX) & rst_n;
    assign lsu_wb_ready_o = (gnt == GNT_LSU) & rst_n;

    // Writes to x0 are accepted but never reach the register file.
    always_comb begin
        wb_d       = wb_q;
        wb_d.valid = 1'b0;
        data_d     = data_q;
        unique case (gnt)
            GNT_EX: begin
                wb_d.valid = (ex_wb_rd_i != '0);
                wb_d.rd    = ex_wb_rd_i;
                data_d     = ex_wb_data_i;
            end
            GNT_LSU: begin
                wb_d.valid = (lsu_wb_rd_i != '0);
                wb_d.rd    = lsu_wb_rd_i;
                data_d     = lsu_wb_data_i;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            rr_q   <= RR_EX;
            wb_q   <= '0;
            data_q <= XLEN'(ZERO_WORD);
        end else begin
            rr_q   <= rr_d;
            wb_q   <= wb_d;
            data_q <= data_d;
        end
    end

    assign rd_req_wr_valid_o = wb_q.valid;
    assign rd_o              = wb_q.rd;
    assign rd_data_o         = data_q;

    reg_scoreboard #(
        .REG_NUM(REG_NUM)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_valid_i(claim_valid_i),
        .set_rd_i   (claim_rd_i),
        .clr_valid_i(wb_q.valid),
        .clr_rd_i   (wb_q.rd),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .rs1_busy_o (rs1_busy_o),
        .rs2_busy_o (rs2_busy_o),
        .pending_o  (pending_o)
    );

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed bench for reg_wb_sched with a per-cycle reference model.
module tb_reg_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_wb_valid_i;
    logic [4:0]  ex_wb_rd_i;
    logic [31:0] ex_wb_data_i;
    logic        ex_wb_ready_o;
    logic        lsu_wb_valid_i;
    logic [4:0]  lsu_wb_rd_i;
    logic [31:0] lsu_wb_data_i;
    logic        lsu_wb_ready_o;
    logic        rd_req_wr_valid_o;
    logic [4:0]  rd_o;
    logic [31:0] rd_data_o;
    logic        claim_valid_i;
    logic [4:0]  claim_rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic [31:0] pending_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_wb_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_wb_valid_i    (ex_wb_valid_i),
        .ex_wb_rd_i       (ex_wb_rd_i),
        .ex_wb_data_i     (ex_wb_data_i),
        .ex_wb_ready_o    (ex_wb_ready_o),
        .lsu_wb_valid_i   (lsu_wb_valid_i),
        .lsu_wb_rd_i      (lsu_wb_rd_i),
        .lsu_wb_data_i    (lsu_wb_data_i),
        .lsu_wb_ready_o   (lsu_wb_ready_o),
        .rd_req_wr_valid_o(rd_req_wr_valid_o),
        .rd_o             (rd_o),
        .rd_data_o        (rd_data_o),
        .claim_valid_i    (claim_valid_i),
        .claim_rd_i       (claim_rd_i),
        .rs1_i            (rs1_i),
        .rs2_i            (rs2_i),
        .rs1_busy_o       (rs1_busy_o),
        .rs2_busy_o       (rs2_busy_o),
        .pending_o        (pending_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: who wins, what gets written next cycle, what is pending.
    logic [31:0] m_pend;
    logic        m_turn_lsu;
    logic        m_out_v;
    logic [4:0]  m_out_rd;
    logic [31:0] m_out_data;
    logic        exp_ex_rdy;
    logic        exp_lsu_rdy;

    assign exp_ex_rdy = rst_n & ex_wb_valid_i &
                        (~lsu_wb_valid_i | ~m_turn_lsu);
    assign exp_lsu_rdy = rst_n & lsu_wb_valid_i &
                         (~ex_wb_valid_i | m_turn_lsu);

    function automatic logic [31:0] next_pend(
        input logic [31:0] cur, input logic wv, input logic [4:0] wrd,
        input logic cv, input logic [4:0] crd);
        logic [31:0] p;
        p = cur;
        if (wv) p[wrd] = 1'b0;
        if (cv && crd != 5'd0) p[crd] = 1'b1;
        return p;
    endfunction

    function automatic logic exp_busy(input logic [4:0] rs);
        return (rs != 5'd0) && m_pend[rs] && !(m_out_v && m_out_rd == rs);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend     <= '0;
            m_turn_lsu <= 1'b0;
            m_out_v    <= 1'b0;
            m_out_rd   <= '0;
            m_out_data <= '0;
        end else begin
            m_pend <= next_pend(m_pend, m_out_v, m_out_rd,
                                claim_valid_i, claim_rd_i);
            if (ex_wb_valid_i && lsu_wb_valid_i)
                m_turn_lsu <= ~m_turn_lsu;
            if (exp_ex_rdy) begin
                m_out_v    <= (ex_wb_rd_i != 5'd0);
                m_out_rd   <= ex_wb_rd_i;
                m_out_data <= ex_wb_data_i;
            end else if (exp_lsu_rdy) begin
                m_out_v    <= (lsu_wb_rd_i != 5'd0);
                m_out_rd   <= lsu_wb_rd_i;
                m_out_data <= lsu_wb_data_i;
            end else begin
                m_out_v <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_ex_ready", ex_wb_ready_o, exp_ex_rdy);
        chk("m_lsu_ready", lsu_wb_ready_o, exp_lsu_rdy);
        chk("m_wr_valid", rd_req_wr_valid_o, m_out_v);
        if (m_out_v) begin
            chk("m_rd", rd_o, m_out_rd);
            chk("m_rd_data", rd_data_o, m_out_data);
        end
        chk("m_pending", pending_o, m_pend);
        chk("m_rs1_busy", rs1_busy_o, exp_busy(rs1_i));
        chk("m_rs2_busy", rs2_busy_o, exp_busy(rs2_i));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_wb_valid_i  = 1'b0;
        ex_wb_rd_i     = '0;
        ex_wb_data_i   = '0;
        lsu_wb_valid_i = 1'b0;
        lsu_wb_rd_i    = '0;
        lsu_wb_data_i  = '0;
        claim_valid_i  = 1'b0;
        claim_rd_i     = '0;
    endtask

    logic [4:0] ex_rd;
    logic [4:0] lsu_rd;
    logic [4:0] win_rd;
    logic       ex_wins;

    initial begin
        rst_n = 1'b0;
        rs1_i = '0;
        rs2_i = '0;
        idle();
        step();
        step();
        chk("rst_wr_valid", rd_req_wr_valid_o, 0);
        chk("rst_rd", rd_o, 0);
        chk("rst_data", rd_data_o, 0);
        chk("rst_pending", pending_o, 0);
        rst_n = 1'b1;

        // Contention from reset: ex, lsu, ex, lsu.
        ex_rd  = 5'd1;
        lsu_rd = 5'd2;
        for (int i = 0; i < 4; i++) begin
            ex_wb_valid_i  = 1'b1;
            ex_wb_rd_i     = ex_rd;
            ex_wb_data_i   = 32'hE000_0000 | 32'(ex_rd);
            lsu_wb_valid_i = 1'b1;
            lsu_wb_rd_i    = lsu_rd;
            lsu_wb_data_i  = 32'h1000_0000 | 32'(lsu_rd);
            #1;
            ex_wins = (i % 2 == 0);
            chk("rr_ex_ready", ex_wb_ready_o, ex_wins);
            chk("rr_lsu_ready", lsu_wb_ready_o, !ex_wins);
            win_rd = ex_wins ? ex_rd : lsu_rd;
            step();
            chk("rr_wr_valid", rd_req_wr_valid_o, 1);
            chk("rr_rd", rd_o, win_rd);
            chk("rr_data", rd_data_o,
                (ex_wins ? 32'hE000_0000 : 32'h1000_0000) | 32'(win_rd));
            if (ex_wins) ex_rd = ex_rd + 5'd2;
            else lsu_rd = lsu_rd + 5'd2;
        end
        idle();

        // Single ex request.
        step();
        ex_wb_valid_i = 1'b1;
        ex_wb_rd_i    = 5'd5;
        ex_wb_data_i  = 32'hDEAD_BEEF;
        #1;
        chk("ex_only_ready", ex_wb_ready_o, 1);
        chk("ex_only_lsu_ready", lsu_wb_ready_o, 0);
        step();
        idle();
        chk("ex_only_wr_valid", rd_req_wr_valid_o, 1);
        chk("ex_only_rd", rd_o, 5);
        chk("ex_only_data", rd_data_o, 32'hDEAD_BEEF);

        // Claim x7, hazard query, retire bypass.
        step();
        claim_valid_i = 1'b1;
        claim_rd_i    = 5'd7;
        step();
        idle();
        rs1_i = 5'd7;
        #1;
        chk("claim7_busy", rs1_busy_o, 1);
        chk("claim7_pend", pending_o[7], 1);
        ex_wb_valid_i = 1'b1;
        ex_wb_rd_i    = 5'd7;
        ex_wb_data_i  = 32'h0000_0077;
        step();
        idle();
        chk("wr7_valid", rd_req_wr_valid_o, 1);
        chk("wr7_rd", rd_o, 7);
        chk("wr7_busy_bypass", rs1_busy_o, 0);
        step();
        chk("wr7_pend_clr", pending_o[7], 0);
        rs1_i = '0;

        // x0 write and x0 claim.
        lsu_wb_valid_i = 1'b1;
        lsu_wb_rd_i    = 5'd0;
        lsu_wb_data_i  = 32'h0000_1234;
        #1;
        chk("x0_lsu_ready", lsu_wb_ready_o, 1);
        step();
        idle();
        claim_valid_i = 1'b1;
        claim_rd_i    = 5'd0;
        #1;
        chk("x0_no_write", rd_req_wr_valid_o, 0);
        step();
        idle();
        chk("x0_claim_pend", pending_o, 0);

        // Claim and retire of x9 in the same cycle.
        claim_valid_i = 1'b1;
        claim_rd_i    = 5'd9;
        ex_wb_valid_i = 1'b1;
        ex_wb_rd_i    = 5'd9;
        ex_wb_data_i  = 32'h0000_0099;
        step();
        ex_wb_valid_i = 1'b0;
        #1;
        chk("x9_wr_valid", rd_req_wr_valid_o, 1);
        chk("x9_rd", rd_o, 9);
        step();
        idle();
        chk("x9_pend_set_wins", pending_o[9], 1);

        // Reset mid-stream with pending bits and writes in flight.
        claim_valid_i = 1'b1;
        claim_rd_i    = 5'd3;
        step();
        claim_rd_i    = 5'd4;
        ex_wb_valid_i = 1'b1;
        ex_wb_rd_i    = 5'd11;
        ex_wb_data_i  = 32'h0000_0011;
        step();
        claim_valid_i = 1'b0;
        ex_wb_rd_i    = 5'd12;
        ex_wb_data_i  = 32'h0000_0012;
        chk("pre_rst_wr_valid", rd_req_wr_valid_o, 1);
        chk("pre_rst_pend", pending_o, 32'h0000_0218);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_valid", rd_req_wr_valid_o, 0);
        chk("mid_rst_rd", rd_o, 0);
        chk("mid_rst_data", rd_data_o, 0);
        chk("mid_rst_pend", pending_o, 0);
        chk("mid_rst_ex_ready", ex_wb_ready_o, 0);
        chk("mid_rst_lsu_ready", lsu_wb_ready_o, 0);
        step();
        step();
        idle();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_write", rd_req_wr_valid_o, 0);
        end
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
